// File: rtl/display_pkg.sv
// Shared types and constants for the three-digit seven-segment scan controller.
package display_pkg;

    localparam int          NDIG    = 3;
    localparam logic [2:0]  AN_OFF  = 3'b111;
    localparam logic [6:0]  SEG_OFF = 7'b1111111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    typedef logic [1:0] dig_t;

    localparam dig_t DIG_LAST = dig_t'(NDIG - 1);

    // One-hot active-low anode pattern for a digit index.
    function automatic logic [2:0] anode_for(input dig_t dig);
        logic [2:0] an;
        case (dig)
            2'd0:    an = 3'b110;
            2'd1:    an = 3'b101;
            2'd2:    an = 3'b011;
            default: an = AN_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/display_slot_timer.sv
// Slot counter, digit index and BLANK/SHOW state; flags the last cycle of each frame.
module display_slot_timer
    import display_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output dig_t        dig_o,
    output scan_state_e state_o,
    output logic        boundary_o
);

    localparam int                CW         = $clog2(PRESCALE);
    localparam logic [CW-1:0]     LAST_CNT   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]     BLANK_CNT  = CW'(BLANK);
    localparam scan_state_e       SLOT_START = (BLANK == 0) ? ST_SHOW : ST_BLANK;

    if (PRESCALE < 2 || BLANK < 0 || BLANK >= PRESCALE) begin : g_bad_params
        $error("display_slot_timer: need PRESCALE >= 2 and 0 <= BLANK < PRESCALE");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    dig_t          dig_q, dig_d;
    scan_state_e   state_q, state_d;

    // Timer state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            dig_q   <= 2'd0;
            state_q <= SLOT_START;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            state_q <= state_d;
        end
    end

    // Slot wrap advances the digit; SHOW begins once the count reaches BLANK.
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        dig_d   = dig_q;
        state_d = state_q;
        if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            dig_d   = (dig_q == DIG_LAST) ? 2'd0 : dig_q + 2'd1;
            state_d = SLOT_START;
        end else if (cnt_d == BLANK_CNT) begin
            state_d = ST_SHOW;
        end else begin
            state_d = state_q;
        end
    end

    assign dig_o      = dig_q;
    assign state_o    = state_q;
    assign boundary_o = (dig_q == DIG_LAST) && (cnt_q == LAST_CNT);

endmodule

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module HexToSeg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Pure lookup; the default covers X inputs in simulation.
    always_comb begin
        case (hex_i)
            4'h0:    seg_o = 7'b1000000;
            4'h1:    seg_o = 7'b1111001;
            4'h2:    seg_o = 7'b0100100;
            4'h3:    seg_o = 7'b0110000;
            4'h4:    seg_o = 7'b0011001;
            4'h5:    seg_o = 7'b0010010;
            4'h6:    seg_o = 7'b0000010;
            4'h7:    seg_o = 7'b1111000;
            4'h8:    seg_o = 7'b0000000;
            4'h9:    seg_o = 7'b0010000;
            4'hA:    seg_o = 7'b0001000;
            4'hB:    seg_o = 7'b0000011;
            4'hC:    seg_o = 7'b1000110;
            4'hD:    seg_o = 7'b0100001;
            4'hE:    seg_o = 7'b0000110;
            4'hF:    seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Three-digit scan controller: double-buffered digit registers swapped at frame
// boundaries, blanking between slots, registered segment/anode drive.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic        clocksource,
    input  logic        reset_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [11:0] wr_data,
    input  logic [2:0]  wr_mask,
    output logic        frame_tick,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    dig_t        dig_s;
    scan_state_e state_s;
    logic        boundary_s;

    display_slot_timer #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_timer (
        .clk_i      (clocksource),
        .rst_n_i    (reset_n),
        .dig_o      (dig_s),
        .state_o    (state_s),
        .boundary_o (boundary_s)
    );

    logic [11:0] act_data_q, act_data_d;
    logic [2:0]  act_mask_q, act_mask_d;
    logic [11:0] sh_data_q,  sh_data_d;
    logic [2:0]  sh_mask_q,  sh_mask_d;
    logic        pending_q,  pending_d;
    logic        wr_ready_q, frame_tick_q;
    logic [6:0]  seg_q, seg_d;
    logic [2:0]  an_q,  an_d;
    logic        accept_s;
    logic [3:0]  nibble_s;
    logic        digit_en_s;
    logic [6:0]  seg_dec_s;

    assign accept_s = wr_valid && wr_ready_q;

    // Shadow/active buffering. A write can only land while nothing is pending,
    // so a write on the boundary cycle is never copied by that same boundary.
    always_comb begin
        act_data_d = act_data_q;
        act_mask_d = act_mask_q;
        sh_data_d  = sh_data_q;
        sh_mask_d  = sh_mask_q;
        pending_d  = pending_q;
        if (boundary_s && pending_q) begin
            act_data_d = sh_data_q;
            act_mask_d = sh_mask_q;
            pending_d  = 1'b0;
        end else if (accept_s) begin
            sh_data_d  = wr_data;
            sh_mask_d  = wr_mask;
            pending_d  = 1'b1;
        end else begin
            pending_d  = pending_q;
        end
    end

    // Nibble and enable for the digit currently being scanned.
    always_comb begin
        nibble_s   = 4'h0;
        digit_en_s = 1'b0;
        case (dig_s)
            2'd0: begin nibble_s = act_data_q[3:0];  digit_en_s = act_mask_q[0]; end
            2'd1: begin nibble_s = act_data_q[7:4];  digit_en_s = act_mask_q[1]; end
            2'd2: begin nibble_s = act_data_q[11:8]; digit_en_s = act_mask_q[2]; end
            default: begin nibble_s = 4'h0; digit_en_s = 1'b0; end
        endcase
    end

    HexToSeg u_hex (
        .hex_i (nibble_s),
        .seg_o (seg_dec_s)
    );

    // Pin drive: dark during blanking and for masked digits.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (state_s == ST_SHOW && digit_en_s) begin
            an_d  = anode_for(dig_s);
            seg_d = seg_dec_s;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    // Buffer, handshake and output registers; wr_ready tracks the next pending
    // value so it drops the cycle right after an accept.
    always_ff @(posedge clocksource) begin
        if (!reset_n) begin
            act_data_q   <= 12'h000;
            act_mask_q   <= 3'b111;
            sh_data_q    <= 12'h000;
            sh_mask_q    <= 3'b000;
            pending_q    <= 1'b0;
            wr_ready_q   <= 1'b0;
            frame_tick_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
        end else begin
            act_data_q   <= act_data_d;
            act_mask_q   <= act_mask_d;
            sh_data_q    <= sh_data_d;
            sh_mask_q    <= sh_mask_d;
            pending_q    <= pending_d;
            wr_ready_q   <= !pending_d;
            frame_tick_q <= boundary_s;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign frame_tick = frame_tick_q;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with PRESCALE=8, BLANK=2 (24-cycle frame).
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_data;
    logic [2:0]  wr_mask;
    logic        frame_tick;
    logic [6:0]  seg;
    logic [2:0]  an;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    display_scan_ctrl #(.PRESCALE(8), .BLANK(2)) dut (
        .clocksource (clk),
        .reset_n     (reset_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_mask     (wr_mask),
        .frame_tick  (frame_tick),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Leaves the bench at cycle 0: the first cycle with reset_n high.
    task automatic apply_reset();
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 12'h000;
        wr_mask  = 3'b000;
        repeat (3) step();
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic check_digit(input string name, input int at, input logic [2:0] ea, input logic [6:0] es);
        run_to(at);
        checks++;
        if (an !== ea || seg !== es) begin
            failures++;
            $display("FAIL %s cyc=%0d an=%b seg=%b required an=%b seg=%b", name, cyc, an, seg, ea, es);
        end
    endtask

    task automatic check_ready(input string name, input int at, input logic er);
        run_to(at);
        checks++;
        if (wr_ready !== er) begin
            failures++;
            $display("FAIL %s cyc=%0d wr_ready=%b required %b", name, cyc, wr_ready, er);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_valid = 1'b0; wr_data = 12'hFFF; wr_mask = 3'b111;
        repeat (2) step();
        checks++;
        if (an !== 3'b111 || seg !== 7'h7F || frame_tick !== 1'b0 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs an=%b seg=%b ft=%b rdy=%b required 111 1111111 0 0", an, seg, frame_tick, wr_ready);
        end
        apply_reset();
        checks++;
        if (an !== 3'b111 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_cycle0 an=%b rdy=%b required 111 0", an, wr_ready);
        end
    endtask

    task automatic test_scan();
        logic [2:0] ea;
        logic [6:0] es;
        logic       eft;
        int         j;
        apply_reset();
        for (int k = 1; k <= 49; k++) begin
            step();
            j   = k - 1;
            eft = ((j % 24) == 23);
            if ((j % 8) < 2) begin
                ea = 3'b111; es = 7'h7F;
            end else begin
                es = 7'h40;
                case ((j / 8) % 3)
                    0: ea = 3'b110;
                    1: ea = 3'b101;
                    default: ea = 3'b011;
                endcase
            end
            checks++;
            if (an !== ea || seg !== es || frame_tick !== eft || wr_ready !== 1'b1) begin
                failures++;
                $display("FAIL scan cyc=%0d an=%b seg=%b ft=%b rdy=%b required %b %b %b 1",
                         cyc, an, seg, frame_tick, wr_ready, ea, es, eft);
            end
        end
    endtask

    task automatic test_write();
        apply_reset();
        check_ready("write_ready_before", 5, 1'b1);
        wr_valid = 1'b1; wr_data = 12'h3A7; wr_mask = 3'b111;
        step();
        wr_valid = 1'b0; wr_data = 12'h000;
        check_ready("write_ready_drop", 6, 1'b0);
        check_digit("write_old_digit2", 19, 3'b011, hex7(4'h0));
        check_ready("write_ready_held", 23, 1'b0);
        check_ready("write_ready_back", 24, 1'b1);
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL write_frame_tick cyc=%0d ft=%b required 1", cyc, frame_tick);
        end
        check_digit("write_blank", 26, 3'b111, 7'h7F);
        check_digit("write_digit0", 27, 3'b110, hex7(4'h7));
        check_digit("write_digit1", 35, 3'b101, hex7(4'hA));
        check_digit("write_digit2", 43, 3'b011, hex7(4'h3));
    endtask

    task automatic test_boundary_write();
        apply_reset();
        check_ready("bnd_ready", 23, 1'b1);
        wr_valid = 1'b1; wr_data = 12'h5C1; wr_mask = 3'b111;
        step();
        wr_valid = 1'b0;
        check_ready("bnd_ready_drop", 24, 1'b0);
        check_digit("bnd_not_applied", 27, 3'b110, hex7(4'h0));
        check_ready("bnd_ready_held", 47, 1'b0);
        check_ready("bnd_ready_back", 48, 1'b1);
        check_digit("bnd_digit0", 51, 3'b110, hex7(4'h1));
        check_digit("bnd_digit1", 59, 3'b101, hex7(4'hC));
        check_digit("bnd_digit2", 67, 3'b011, hex7(4'h5));
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_to(2);
        wr_valid = 1'b1; wr_data = 12'h111; wr_mask = 3'b111;
        step();
        wr_data = 12'h222;
        check_ready("b2b_blocked", 3, 1'b0);
        run_to(10);
        wr_data = 12'h999;
        check_ready("b2b_blocked_late", 23, 1'b0);
        check_ready("b2b_ready_back", 24, 1'b1);
        wr_data = 12'h456;
        step();
        wr_valid = 1'b0; wr_data = 12'hEEE;
        check_ready("b2b_second_taken", 25, 1'b0);
        check_digit("b2b_first_d0", 27, 3'b110, hex7(4'h1));
        check_digit("b2b_first_d1", 35, 3'b101, hex7(4'h1));
        check_digit("b2b_second_d0", 51, 3'b110, hex7(4'h6));
        check_digit("b2b_second_d1", 59, 3'b101, hex7(4'h5));
        check_digit("b2b_second_d2", 67, 3'b011, hex7(4'h4));
    endtask

    task automatic test_mask();
        apply_reset();
        run_to(1);
        wr_valid = 1'b1; wr_data = 12'h888; wr_mask = 3'b101;
        step();
        wr_valid = 1'b0;
        check_digit("mask_digit0", 27, 3'b110, hex7(4'h8));
        for (int k = 33; k <= 40; k++) check_digit("mask_digit1_dark", k, 3'b111, 7'h7F);
        check_digit("mask_digit2", 43, 3'b011, hex7(4'h8));
        for (int k = 47; k <= 72; k += 24) begin
            run_to(k);
            checks++;
            if (frame_tick !== 1'b0) begin
                failures++;
                $display("FAIL mask_ft_low cyc=%0d ft=%b required 0", cyc, frame_tick);
            end
            step();
            checks++;
            if (frame_tick !== 1'b1) begin
                failures++;
                $display("FAIL mask_ft_high cyc=%0d ft=%b required 1", cyc, frame_tick);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        run_to(18);
        wr_valid = 1'b1; wr_data = 12'hBCD; wr_mask = 3'b111;
        step();
        wr_valid = 1'b0;
        check_ready("rst_pending", 19, 1'b0);
        run_to(20);
        reset_n = 1'b0;
        step();
        checks++;
        if (an !== 3'b111 || seg !== 7'h7F || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid an=%b seg=%b rdy=%b required 111 1111111 0", an, seg, wr_ready);
        end
        step();
        reset_n = 1'b1;
        cyc = 0;
        check_ready("rst_ready_back", 1, 1'b1);
        check_digit("rst_d0_first", 3, 3'b110, hex7(4'h0));
        check_digit("rst_d0", 27, 3'b110, hex7(4'h0));
        check_digit("rst_d1", 35, 3'b101, hex7(4'h0));
        check_digit("rst_d2", 43, 3'b011, hex7(4'h0));
        check_digit("rst_d0_late", 51, 3'b110, hex7(4'h0));
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 12'h000;
        wr_mask  = 3'b000;
        test_reset();
        test_scan();
        test_write();
        test_boundary_write();
        test_back_to_back();
        test_mask();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
